// File: rtl/imem_pkg.sv
// Shared types and sizing for the instruction-memory boot loader.
package imem_pkg;

  localparam int IMEM_DWIDTH    = 32;
  localparam int IMEM_AWIDTH    = 10;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port; master is the loader side.
interface imem_loader_if
  import imem_pkg::*;
#(
  parameter int DWIDTH = IMEM_DWIDTH,
  parameter int AWIDTH = IMEM_AWIDTH
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              we;
  logic [AWIDTH-1:0] waddr;
  logic [DWIDTH-1:0] wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, we, waddr, wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, we, waddr, wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles accepted bytes big-endian into a word; word_valid pulses with the last byte.
module byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;

  assign word       = {sr_q, in_data};
  assign word_valid = accept && (cnt_q == 2'(BYTES_PER_WORD - 1));

  // A state change restarts the count so every phase begins on a word boundary.
  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (accept) begin
      cnt_d = cnt_q + 2'd1;
      sr_d  = {sr_q[15:0], in_data};
    end
    if (clear) begin
      cnt_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 2'd0;
      sr_q  <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: header word N, then N big-endian data words.
// Optional trailing checksum word enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DWIDTH = IMEM_DWIDTH,
  parameter int AWIDTH = IMEM_AWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  imem_loader_if.master     bus,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [AWIDTH:0]   word_count
);

  localparam logic [DWIDTH-1:0] MAX_WORDS = {{(DWIDTH-1){1'b0}}, 1'b1} << AWIDTH;
  localparam logic [AWIDTH:0]   ONE_WORD  = {{AWIDTH{1'b0}}, 1'b1};

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t END_STATE = CSUM;
`else
  localparam loader_state_t END_STATE = DONE;
`endif

  loader_state_t     state_q, state_d;
  logic [AWIDTH:0]   word_count_q, word_count_d;
  logic [AWIDTH:0]   n_q, n_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              in_ready;
  logic              word_valid;
  logic [31:0]       word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DWIDTH-1:0] csum_q, csum_d;
`endif

  assign in_ready = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_d != state_q),
    .accept     (bus.in_valid && in_ready),
    .in_data    (bus.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    n_d          = n_q;
    wdata_d      = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d      = HDR;
          word_count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d       = '0;
`endif
        end
      end
      // N is range-checked here so no later write can run past the memory.
      HDR: begin
        if (word_valid) begin
          if (word == '0) begin
            state_d = END_STATE;
          end else if (word > MAX_WORDS) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
            n_d     = word[AWIDTH:0];
          end
        end
      end
      DATA: begin
        if (word_valid) begin
          wdata_d = word;
          state_d = WRITE;
        end
      end
      WRITE: begin
        word_count_d = word_count_q + ONE_WORD;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d       = csum_q + wdata_q;
`endif
        state_d      = (word_count_d == n_q) ? END_STATE : DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        if (word_valid) begin
          state_d = (word == csum_q) ? DONE : ERR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      word_count_q <= '0;
      n_q          <= '0;
      wdata_q      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      n_q          <= n_d;
      wdata_q      <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.we       = (state_q == WRITE);
  assign bus.waddr    = word_count_q[AWIDTH-1:0];
  assign bus.wdata    = wdata_q;
  assign cpu_hold     = (state_q == HDR) || (state_q == DATA) || (state_q == WRITE) ||
                        (state_q == CSUM) || (state_q == ERR);
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERR);
  assign word_count   = word_count_q;

endmodule
